// File: rtl/data_mem_arbiter_if.sv
// Data-memory sharing bus: core MEM-stage port, secondary (debug/DMA) port and the muxed memory port.
// The arbiter takes the slave modport; the pipeline/requester/memory side takes the master modport.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              core_req;
   logic              core_we;
   logic [2:0]        core_funct3;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_stall;
   logic [DATA_W-1:0] core_rdata;
   logic              core_rvalid;

   logic              dbg_req;
   logic              dbg_we;
   logic [2:0]        dbg_funct3;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_rvalid;

   logic              mem_en;
   logic              mem_we;
   logic [2:0]        mem_funct3;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req, core_we, core_funct3, core_addr, core_wdata,
      output core_stall, core_rdata, core_rvalid,
      input  dbg_req, dbg_we, dbg_funct3, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rdata, dbg_rvalid,
      output mem_en, mem_we, mem_funct3, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_funct3, core_addr, core_wdata,
      input  core_stall, core_rdata, core_rvalid,
      output dbg_req, dbg_we, dbg_funct3, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rdata, dbg_rvalid,
      input  mem_en, mem_we, mem_funct3, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Core-priority arbiter for the data-memory port; stores ack in the issue cycle, loads respond 1 cycle later.
// Core is stalled until its access completes; DATA_MEM_ARB_FAIRNESS_EN adds a MAX_WAIT starvation guard for dbg.
module data_mem_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 8
) (
   input logic              clk,
   input logic              rst,
   data_mem_arbiter_if.slave bus
);

   if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
      $error("data_mem_arbiter: MAX_WAIT must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CORE_RD = 2'd1,
      DBG_RD  = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [2:0]        funct3;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t state_q, state_d;
   req_t   core_r, dbg_r, mem_r;
   logic   core_elig, dbg_elig, force_dbg;
   logic   core_gnt, dbg_gnt_w;
   logic   core_rvalid_w, dbg_rvalid_w;

   assign core_r = '{we: bus.core_we, funct3: bus.core_funct3, addr: bus.core_addr, wdata: bus.core_wdata};
   assign dbg_r  = '{we: bus.dbg_we,  funct3: bus.dbg_funct3,  addr: bus.dbg_addr,  wdata: bus.dbg_wdata};

   // A requester whose load response is on the bus this cycle cannot reissue yet.
   assign core_elig = bus.core_req && (state_q != CORE_RD);
   assign dbg_elig  = bus.dbg_req  && (state_q != DBG_RD);

`ifdef DATA_MEM_ARB_FAIRNESS_EN
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
   logic [7:0] wait_cnt;

   assign force_dbg = (wait_cnt == MAX_WAIT_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (bus.dbg_req && !dbg_gnt_w) begin
         if (wait_cnt != MAX_WAIT_C) wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= '0;
      end
   end
`else
   assign force_dbg = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = IDLE;
      core_gnt  = 1'b0;
      dbg_gnt_w = 1'b0;
      mem_r     = '0;
      if (!rst) begin
         if (dbg_elig && (!core_elig || force_dbg)) dbg_gnt_w = 1'b1;
         else if (core_elig)                        core_gnt  = 1'b1;
      end
      if (core_gnt) begin
         mem_r = core_r;
         if (!core_r.we) state_d = CORE_RD;
      end else if (dbg_gnt_w) begin
         mem_r = dbg_r;
         if (!dbg_r.we) state_d = DBG_RD;
      end
   end

   // Reset in the response cycle suppresses the pending load response.
   assign core_rvalid_w = (state_q == CORE_RD) && !rst;
   assign dbg_rvalid_w  = (state_q == DBG_RD)  && !rst;

   assign bus.mem_en     = core_gnt | dbg_gnt_w;
   assign bus.mem_we     = mem_r.we;
   assign bus.mem_funct3 = mem_r.funct3;
   assign bus.mem_addr   = mem_r.addr;
   assign bus.mem_wdata  = mem_r.wdata;

   assign bus.core_rvalid = core_rvalid_w;
   assign bus.core_rdata  = core_rvalid_w ? bus.mem_rdata : '0;
   assign bus.core_stall  = bus.core_req && !((core_gnt && core_r.we) || core_rvalid_w);

   assign bus.dbg_gnt    = dbg_gnt_w;
   assign bus.dbg_rvalid = dbg_rvalid_w;
   assign bus.dbg_rdata  = dbg_rvalid_w ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random two-requester traffic against a scoreboard.
module tb_data_mem_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int MW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int compared   = 0;
   int mismatched = 0;
   logic [63:0] core_q[$];
   logic [63:0] dbg_q[$];
   logic [AW-1:0] last_addr = '0;

   // Memory returns a fixed function of the last loaded address; 0x100 maps to 0xDEADBEEF.
   function automatic logic [63:0] rd_fn(input logic [63:0] a);
      return 64'hDEADBEEF + (a - 64'h100) * 64'h9E3779B97F4A7C15;
   endfunction

   always @(posedge clk) if (bus.mem_en && !bus.mem_we) last_addr <= bus.mem_addr;
   assign bus.mem_rdata = rd_fn(last_addr);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string nm);
      compared++;
      mismatched++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input logic r, input logic w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
      bus.core_req = r; bus.core_we = w; bus.core_funct3 = f; bus.core_addr = a; bus.core_wdata = d;
   endtask

   task automatic set_dbg(input logic r, input logic w, input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
      bus.dbg_req = r; bus.dbg_we = w; bus.dbg_funct3 = f; bus.dbg_addr = a; bus.dbg_wdata = d;
   endtask

   // Reference model: which requester is entitled to the port, written from the observable rules.
   bit core_due = 0, dbg_due = 0, core_done = 0, dbg_done = 0;
   int wcnt = 0;

   always @(negedge clk) begin
      bit core_el, dbg_el, forced, e_dbg, e_core;
      core_el = bus.core_req && !core_due;
      dbg_el  = bus.dbg_req && !dbg_due;
`ifdef DATA_MEM_ARB_FAIRNESS_EN
      forced = (wcnt == MW);
`else
      forced = 1'b0;
`endif
      e_dbg  = !rst && dbg_el && (!core_el || forced);
      e_core = !rst && core_el && !e_dbg;

      chk("dbg_gnt", {63'd0, bus.dbg_gnt}, {63'd0, e_dbg});
      chk("mem_en", {63'd0, bus.mem_en}, {63'd0, e_dbg | e_core});
      chk("core_rvalid", {63'd0, bus.core_rvalid}, {63'd0, core_due && !rst});
      chk("dbg_rvalid", {63'd0, bus.dbg_rvalid}, {63'd0, dbg_due && !rst});
      chk("core_stall", {63'd0, bus.core_stall},
          {63'd0, bus.core_req && !((e_core && bus.core_we) || (core_due && !rst))});

      if (e_dbg) begin
         chk("mem_ctl_dbg", {60'd0, bus.mem_we, bus.mem_funct3}, {60'd0, bus.dbg_we, bus.dbg_funct3});
         chk("mem_addr_dbg", bus.mem_addr, bus.dbg_addr);
         chk("mem_wdata_dbg", bus.mem_wdata, bus.dbg_wdata);
      end else if (e_core) begin
         chk("mem_ctl_core", {60'd0, bus.mem_we, bus.mem_funct3}, {60'd0, bus.core_we, bus.core_funct3});
         chk("mem_addr_core", bus.mem_addr, bus.core_addr);
         chk("mem_wdata_core", bus.mem_wdata, bus.core_wdata);
      end else begin
         chk("mem_idle", {60'd0, bus.mem_we, bus.mem_funct3} | bus.mem_addr | bus.mem_wdata, 64'd0);
      end

      if (bus.core_rvalid) begin
         if (core_q.size() == 0) note_fail("core_rvalid_unexpected");
         else chk("core_rdata", bus.core_rdata, core_q.pop_front());
      end else chk("core_rdata_zero", bus.core_rdata, 64'd0);
      if (bus.dbg_rvalid) begin
         if (dbg_q.size() == 0) note_fail("dbg_rvalid_unexpected");
         else chk("dbg_rdata", bus.dbg_rdata, dbg_q.pop_front());
      end else chk("dbg_rdata_zero", bus.dbg_rdata, 64'd0);

      core_due = e_core && !bus.core_we;
      dbg_due  = e_dbg && !bus.dbg_we;
`ifdef DATA_MEM_ARB_FAIRNESS_EN
      if (rst) wcnt = 0;
      else if (bus.dbg_req && !e_dbg) wcnt = (wcnt < MW) ? wcnt + 1 : MW;
      else wcnt = 0;
`endif
      core_done = bus.core_req && !bus.core_stall;
      dbg_done  = bus.dbg_gnt;
   end

   task automatic start_core;
      logic [63:0] a;
      logic w;
      a = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      set_core(1'b1, w, 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
      if (!w) core_q.push_back(rd_fn(a));
   endtask

   task automatic start_dbg;
      logic [63:0] a;
      logic w;
      a = {$urandom, $urandom};
      w = 1'($urandom_range(0, 1));
      set_dbg(1'b1, w, 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
      if (!w) dbg_q.push_back(rd_fn(a));
   endtask

   initial begin
      int gnt_at;
      set_core(0, 0, 0, 0, 0);
      set_dbg(0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) tick;

      // Reset: core request is stalled and nothing reaches memory.
      set_core(1, 0, 3'b011, 64'h300, 0);
      @(negedge clk);
      chk("rst_stall", {63'd0, bus.core_stall}, 64'd1);
      chk("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
      tick;
      rst = 1'b0;
      set_core(0, 0, 0, 0, 0);

      // Uncontended core load.
      tick;
      set_core(1, 0, 3'b011, 64'h100, 0);
      core_q.push_back(64'hDEADBEEF);
      @(negedge clk);
      chk("ld_mem_en", {63'd0, bus.mem_en}, 64'd1);
      chk("ld_stall_n", {63'd0, bus.core_stall}, 64'd1);
      chk("ld_addr", bus.mem_addr, 64'h100);
      tick;
      @(negedge clk);
      chk("ld_stall_n1", {63'd0, bus.core_stall}, 64'd0);
      chk("ld_rvalid", {63'd0, bus.core_rvalid}, 64'd1);
      chk("ld_rdata", bus.core_rdata, 64'hDEADBEEF);

      // Uncontended core store.
      tick;
      set_core(1, 1, 3'b011, 64'h200, 64'h55);
      @(negedge clk);
      chk("st_mem_en", {63'd0, bus.mem_en}, 64'd1);
      chk("st_mem_we", {63'd0, bus.mem_we}, 64'd1);
      chk("st_stall", {63'd0, bus.core_stall}, 64'd0);
      chk("st_wdata", bus.mem_wdata, 64'h55);

      // Core store and dbg load together.
      tick;
      set_core(1, 1, 3'b011, 64'h208, 64'hAA);
      set_dbg(1, 0, 3'b011, 64'h400, 0);
      dbg_q.push_back(rd_fn(64'h400));
      @(negedge clk);
      chk("ct_core_first", {62'd0, bus.mem_we, bus.dbg_gnt}, 64'd2);
      tick;
      set_core(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("ct_dbg_gnt", {63'd0, bus.dbg_gnt}, 64'd1);
      tick;
      set_dbg(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("ct_dbg_rvalid", {63'd0, bus.dbg_rvalid}, 64'd1);

      // Continuous core stores against a waiting dbg store.
      tick;
      set_core(1, 1, 3'b010, 64'h210, 64'h1);
      set_dbg(1, 1, 3'b010, 64'h500, 64'h77);
      gnt_at = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.dbg_gnt && gnt_at < 0) gnt_at = k;
`ifdef DATA_MEM_ARB_FAIRNESS_EN
         if (k == 3) chk("sv_stall_forced", {63'd0, bus.core_stall}, 64'd1);
         if (k == 4) chk("sv_core_resume", {62'd0, bus.core_stall, bus.mem_en}, 64'd1);
`endif
         tick;
         if (gnt_at >= 0) set_dbg(0, 0, 0, 0, 0);
      end
`ifdef DATA_MEM_ARB_FAIRNESS_EN
      chk("sv_gnt_cycle", 64'(gnt_at), 64'd3);
      set_core(0, 0, 0, 0, 0);
`else
      chk("sv_no_gnt", 64'(gnt_at), 64'hFFFF_FFFF_FFFF_FFFF);
      set_core(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("sv_gnt_after_core", {63'd0, bus.dbg_gnt}, 64'd1);
      tick;
      set_dbg(0, 0, 0, 0, 0);
`endif

      // Reset in the response cycle of a dbg load.
      tick;
      set_dbg(1, 0, 3'b011, 64'h600, 0);
      dbg_q.push_back(rd_fn(64'h600));
      @(negedge clk);
      chk("rl_gnt", {63'd0, bus.dbg_gnt}, 64'd1);
      tick;
      rst = 1'b1;
      set_dbg(0, 0, 0, 0, 0);
      dbg_q.delete();
      core_q.delete();
      @(negedge clk);
      chk("rl_rvalid_n1", {63'd0, bus.dbg_rvalid}, 64'd0);
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk("rl_rvalid_n2", {62'd0, bus.dbg_rvalid, bus.mem_en}, 64'd0);

      // Random traffic with occasional resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick;
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            set_core(0, 0, 0, 0, 0);
            set_dbg(0, 0, 0, 0, 0);
            core_q.delete();
            dbg_q.delete();
         end else begin
            rst = 1'b0;
            if (bus.core_req && core_done) begin
               if ($urandom_range(0, 1) == 0) set_core(0, 0, 0, 0, 0);
               else start_core();
            end else if (!bus.core_req && $urandom_range(0, 9) < 7) start_core();
            if (bus.dbg_req && dbg_done) begin
               if ($urandom_range(0, 1) == 0) set_dbg(0, 0, 0, 0, 0);
               else start_dbg();
            end else if (!bus.dbg_req && $urandom_range(0, 9) < 4) start_dbg();
         end
      end

      // Drain outstanding requests.
      tick;
      rst = 1'b0;
      for (int i = 0; i < 50 && (bus.core_req || bus.dbg_req); i++) begin
         tick;
         if (core_done) set_core(0, 0, 0, 0, 0);
         if (dbg_done) set_dbg(0, 0, 0, 0, 0);
      end
      chk("drain_idle", {62'd0, bus.core_req, bus.dbg_req}, 64'd0);
      repeat (3) tick;
      chk("core_q_empty", 64'(core_q.size()), 64'd0);
      chk("dbg_q_empty", 64'(dbg_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
